// File: rtl/fft_stage_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_stage_sequencer_if : control/status bundle between frame logic, the FFT
// core and the stage sequencer.                           Revision: 1.0
// ----------------------------------------------------------------------------
interface fft_stage_sequencer_if #(
  parameter int STAGE_W = 4,
  parameter int MUL_W   = 4
);
  logic               start;
  logic               hold;
  logic               abort;
  logic [STAGE_W-1:0] stage_select;
  logic [MUL_W-1:0]   mul_count;
  logic               mul_active;
  logic               busy;
  logic               done;
  logic [7:0]         cycle_count;

  modport master (
    output start, hold, abort,
    input  stage_select, mul_count, mul_active, busy, done, cycle_count
  );

  modport slave (
    input  start, hold, abort,
    output stage_select, mul_count, mul_active, busy, done, cycle_count
  );
endinterface
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_stage_sequencer : steps the FFT core through the stages of one frame,
// dwelling MUL_LEN cycles on multiply stages.             Revision: 1.0
// ----------------------------------------------------------------------------
module fft_stage_sequencer #(
  parameter int                    NUM_STAGES     = 16,
  parameter int                    STAGE_W        = 4,
  parameter int                    MUL_LEN        = 16,
  parameter int                    MUL_W          = 4,
  parameter logic [NUM_STAGES-1:0] MUL_STAGE_MASK = 16'h2AA8
) (
  input  wire                           clk,
  input  wire                           rst,
  fft_stage_sequencer_if.slave          ctl_if
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Mask widened to the full stage_select range so any index is in bounds.
  localparam int                  C_MASK_W   = 2 ** STAGE_W;
  localparam logic [C_MASK_W-1:0] c_mul_mask = C_MASK_W'(MUL_STAGE_MASK);
  localparam logic [STAGE_W-1:0]  c_last_stg = STAGE_W'(NUM_STAGES - 1);
  localparam logic [MUL_W-1:0]    c_last_mul = MUL_W'(MUL_LEN - 1);

  state_t             state_q, state_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [MUL_W-1:0]   mul_q,   mul_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic [7:0]         cyc_q,   cyc_d;

  logic               w_is_mul;
  logic               w_mul_more;
  logic [7:0]         w_cyc_inc;

  assign w_is_mul   = c_mul_mask[stage_q];
  assign w_mul_more = w_is_mul && (mul_q != c_last_mul);
  assign w_cyc_inc  = (cyc_q == 8'hFF) ? cyc_q : cyc_q + 8'd1;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    mul_d   = mul_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cyc_d   = cyc_q;
    case (state_q)
      S_IDLE: begin
        if (ctl_if.start) begin
          state_d = S_RUN;
          stage_d = '0;
          mul_d   = '0;
          busy_d  = 1'b1;
          cyc_d   = 8'd1;
        end
      end
      S_RUN: begin
        if (ctl_if.abort) begin
          state_d = S_IDLE;
          stage_d = '0;
          mul_d   = '0;
          busy_d  = 1'b0;
        end else if (!ctl_if.hold) begin
          if (w_mul_more) begin
            mul_d = mul_q + MUL_W'(1);
            cyc_d = w_cyc_inc;
          end else if (stage_q != c_last_stg) begin
            stage_d = stage_q + STAGE_W'(1);
            mul_d   = '0;
            cyc_d   = w_cyc_inc;
          end else begin
            // Leaving RUN: the count already covers the final RUN cycle.
            state_d = S_IDLE;
            stage_d = '0;
            mul_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        stage_d = '0;
        mul_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      mul_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      mul_q   <= mul_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end

  assign ctl_if.stage_select = stage_q;
  assign ctl_if.mul_count    = mul_q;
  assign ctl_if.mul_active   = w_is_mul & busy_q;
  assign ctl_if.busy         = busy_q;
  assign ctl_if.done         = done_q;
  assign ctl_if.cycle_count  = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fft_stage_sequencer : directed frames with a queue-based scoreboard.
//                                                         Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fft_stage_sequencer;

  localparam logic [15:0] MASK      = 16'h2AA8;
  localparam int          FRAME_LEN = 106;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] mul;
    logic       busy;
    logic       done;
    logic       ma;
    logic [7:0] cc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_stage_sequencer_if #(.STAGE_W(4), .MUL_W(4)) bus ();

  fft_stage_sequencer #(
    .NUM_STAGES(16), .STAGE_W(4), .MUL_LEN(16), .MUL_W(4), .MUL_STAGE_MASK(MASK)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .ctl_if(bus.slave)
  );

  int   total = 0;
  int   bad   = 0;
  int   dones_seen = 0;
  int   dones_exp  = 0;
  exp_t q[$];
  logic [3:0] seq_st[$];
  logic [3:0] seq_mul[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic exp_t cur_out();
    exp_t a;
    a.st   = bus.stage_select;
    a.mul  = bus.mul_count;
    a.busy = bus.busy;
    a.done = bus.done;
    a.ma   = bus.mul_active;
    a.cc   = bus.cycle_count;
    return a;
  endfunction

  // Monitor: every cycle the DUT shows busy or done must match the next queued entry.
  always @(negedge clk) begin
    exp_t a;
    exp_t e;
    if (bus.busy === 1'b1 || bus.done === 1'b1) begin
      a = cur_out();
      if (bus.done === 1'b1) dones_seen++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=%h required=none", a);
      end else begin
        e = q.pop_front();
        check("scoreboard", 32'(a), 32'(e));
      end
    end
  end

  function automatic exp_t mk(input int idx);
    exp_t e;
    e.st   = seq_st[idx];
    e.mul  = seq_mul[idx];
    e.busy = 1'b1;
    e.done = 1'b0;
    e.ma   = MASK[seq_st[idx]];
    e.cc   = 8'(idx + 1);
    return e;
  endfunction

  function automatic int find_idx(input int s, input int m);
    for (int i = 0; i < seq_st.size(); i++)
      if (seq_st[i] == 4'(s) && seq_mul[i] == 4'(m)) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int hold_idx, input int hold_len, input int abort_idx,
                           input int start_idx, input int rst_idx);
    int   cur;
    int   held;
    exp_t d;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cur  = 0;
    held = 0;
    q.push_back(mk(0));
    for (int n = 0; n < 400; n++) begin
      if (cur == abort_idx) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_outputs", {23'd0, bus.stage_select, bus.mul_count, bus.busy},
              32'd0);
        check("abort_no_done", {31'd0, bus.done}, 32'd0);
        return;
      end
      if (cur == rst_idx) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midframe_reset", 32'(cur_out()), 32'd0);
        return;
      end
      if (cur == hold_idx && held < hold_len) begin
        bus.hold = 1'b1;
        tick();
        bus.hold = 1'b0;
        held++;
        q.push_back(mk(cur));
        continue;
      end
      bus.start = (cur == start_idx);
      tick();
      bus.start = 1'b0;
      if (cur == FRAME_LEN - 1) begin
        d      = '0;
        d.done = 1'b1;
        d.cc   = 8'(FRAME_LEN);
        q.push_back(d);
        dones_exp++;
        return;
      end
      cur++;
      q.push_back(mk(cur));
    end
    total++;
    bad++;
    $display("FAIL frame_bound actual=%0d required<%0d", cur, FRAME_LEN);
  endtask

  task automatic idle_check(input string name, input logic [7:0] cc);
    exp_t e;
    e    = '0;
    e.cc = cc;
    check(name, 32'(cur_out()), 32'(e));
  endtask

  initial begin
    for (int s = 0; s < 16; s++) begin
      if (MASK[s]) begin
        for (int m = 0; m < 16; m++) begin
          seq_st.push_back(4'(s));
          seq_mul.push_back(4'(m));
        end
      end else begin
        seq_st.push_back(4'(s));
        seq_mul.push_back(4'd0);
      end
    end

    // Reset held with start asserted: nothing may begin.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    tick();
    idle_check("reset_cycle1", 8'd0);
    tick();
    idle_check("reset_cycle2", 8'd0);
    rst = 1'b0;

    run_frame(-1, 0, -1, -1, -1);
    tick();
    idle_check("idle_after_full", 8'd106);

    run_frame(find_idx(5, 7), 5, -1, -1, -1);
    tick();
    idle_check("idle_after_hold", 8'd106);

    run_frame(-1, 0, find_idx(9, 3), -1, -1);
    bus.abort = 1'b1;
    tick();
    check("abort_in_idle", {31'd0, bus.busy}, 32'd0);
    // abort stays high on the start edge: start must win.
    run_frame(-1, 0, -1, -1, -1);
    tick();
    idle_check("idle_after_abort_frame", 8'd106);

    // Extra start mid-frame, then a back-to-back frame held on its last stage.
    run_frame(-1, 0, -1, find_idx(4, 0), -1);
    run_frame(find_idx(15, 0), 3, -1, -1, -1);
    tick();
    idle_check("idle_after_b2b", 8'd106);

    run_frame(-1, 0, -1, -1, find_idx(11, 10));
    tick();
    idle_check("idle_after_midreset", 8'd0);
    tick();

    check("queue_drained", 32'(q.size()), 32'd0);
    check("done_pulses", 32'(dones_seen), 32'(dones_exp));
    check("done_pulse_total", 32'(dones_seen), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Controller that sequences the FFT datapath through its 16 stages for one 128-point frame. It drives the FFT's stage_select and mul_count inputs, replacing hand-driven stimulus. Butterfly/twiddle-multiply stages dwell MUL_LEN cycles stepping mul_count; all other stages dwell one cycle. It sits between the frame-load logic (start) and the FFT core, and reports busy/done to the output consumer.

Parameters:
NUM_STAGES, 16, number of stages per frame; stage_select counts 0..NUM_STAGES-1
STAGE_W, 4, width of stage_select; must satisfy 2**STAGE_W >= NUM_STAGES
MUL_LEN, 16, dwell cycles of a multiply stage; mul_count counts 0..MUL_LEN-1
MUL_W, 4, width of mul_count; must satisfy 2**MUL_W >= MUL_LEN
MUL_STAGE_MASK, 16'h2AA8, bit i set = stage i is a multiply stage (default: stages 3,5,7,9,11,13)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request to process one frame; sampled only in IDLE
hold  in  1  stall; freezes stage_select/mul_count while RUN
abort  in  1  cancel current frame; returns to IDLE without done
stage_select  out  STAGE_W  stage index to FFT core
mul_count  out  MUL_W  multiply sub-step index to FFT core
mul_active  out  1  combinational: MUL_STAGE_MASK[stage_select] & busy
busy  out  1  high while in RUN
done  out  1  one-cycle pulse after the last stage completes
cycle_count  out  8  cycles spent in RUN for the current/last frame, excluding hold cycles

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, stage_select=0, mul_count=0, busy=0, done=0, cycle_count=0. rst overrides all other inputs, including mid-frame.
- States: IDLE, RUN. Priority within RUN: rst > abort > hold > advance.
- IDLE: outputs held at 0 (cycle_count keeps last frame's value). start=1 at an edge -> RUN, stage_select=0, mul_count=0, busy=1, cycle_count=1. done is cleared at every edge where it is not being asserted.
- RUN, hold=1: all registers unchanged, including cycle_count.
- RUN advance (hold=0, abort=0), cycle_count increments by 1 (saturates at 255):
  - multiply stage and mul_count<MUL_LEN-1: mul_count+1, stage unchanged.
  - otherwise, stage_select<NUM_STAGES-1: stage_select+1, mul_count=0.
  - otherwise (last stage, final cycle): state=IDLE, busy=0, done=1 for exactly one cycle, stage_select=0, mul_count=0.
- Frame length with defaults: 10 single-cycle stages + 6x16 = 106 RUN cycles; done asserts on the edge after the 106th RUN cycle.
- abort=1 in RUN: next edge -> IDLE, outputs 0, done stays 0. abort in IDLE is ignored; abort and start together in IDLE: start wins.
- start while busy: ignored (no restart, no queueing).
- start during the done cycle (state already IDLE): accepted; RUN begins next edge, giving back-to-back frames with no idle gap beyond the done cycle.
- hold on the last cycle of a multiply stage or last stage: the transition is deferred until hold drops.
- If the last stage is marked as a multiply stage, done follows its mul_count=MUL_LEN-1 cycle.
- No combinational path from start/hold/abort to any output except mul_active (which depends on registered state only).

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> stage_select=0, mul_count=0, busy=0, done=0 throughout; the frame starts only after rst drops.
- Full frame: start pulse -> stage sequence 0,1,2,3x16 (mul 0..15),4,5x16,6,7x16,8,9x16,10,11x16,12,13x16,14,15; busy high for 106 cycles; one done pulse; cycle_count=106.
- Hold: assert hold for 5 cycles at stage 5, mul_count=7 -> values frozen; resumes at mul_count=8; done arrives 5 cycles later; cycle_count=106.
- Abort: abort at stage 9, mul_count=3 -> next cycle busy=0, stage_select=0, no done; a following start runs a complete 106-cycle frame.
- Start while busy and back-to-back: extra start at stage 4 is ignored; start during the done cycle -> the second frame begins on the next edge, with exactly two done pulses total.
- Reset mid-frame: rst at stage 11, mul_count=10 -> all outputs 0 next edge; no done pulse.
